rr_output_port_arbiter: RTL and testbench

//  Per-output-port wormhole arbiter for the 5-port NOC router (N,S,W,E,L).
//  It grants one input port at a time and holds that grant until the port's tail flit transfers.

---
 rtl/noc_arb_pkg.sv | 33 +++
 rtl/rr_mask_pick.sv | 31 +++
 rtl/rr_output_port_arbiter.sv | 92 +++++++++
 tb/tb_rr_output_port_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/noc_arb_pkg.sv
// Shared port encodings and state type for the NOC router output-port arbiters.
// Port index order is N=4 .. L=0. The mux select code counts the other way, N=000 .. L=100.
package noc_arb_pkg;

    localparam int unsigned NUM_PORTS = 5;
    localparam int unsigned SEL_W     = 3;

    typedef logic [2:0]       port_idx_t;
    typedef logic [SEL_W-1:0] port_sel_t;

    localparam port_idx_t P_N = 3'd4;
    localparam port_idx_t P_S = 3'd3;
    localparam port_idx_t P_W = 3'd2;
    localparam port_idx_t P_E = 3'd1;
    localparam port_idx_t P_L = 3'd0;

    localparam port_sel_t SEL_N = 3'b000;
    localparam port_sel_t SEL_S = 3'b001;
    localparam port_sel_t SEL_W_CODE = 3'b010;
    localparam port_sel_t SEL_E = 3'b011;
    localparam port_sel_t SEL_L = 3'b100;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

    // The select code is the port index mirrored about N.
    function automatic port_sel_t idx_to_sel(input port_idx_t idx);
        return port_sel_t'(P_N - idx);
    endfunction

endpackage

// File: rtl/rr_mask_pick.sv
// Combinational round-robin pick: the highest-index requester inside the pointer
// window wins; if nobody is inside the window, the highest-index requester overall wins.
module rr_mask_pick
    import noc_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] ptr,
    output logic [NUM_PORTS-1:0] winner,
    output port_sel_t            sel,
    output logic                 any
);

    logic [NUM_PORTS-1:0] masked;
    logic [NUM_PORTS-1:0] pool;
    port_idx_t            idx;

    always_comb begin
        masked = req & ptr;
        pool   = (|masked) ? masked : req;
        idx    = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (pool[i]) begin
                idx = port_idx_t'(i);
            end
        end
        any    = |req;
        winner = any ? (NUM_PORTS'(1) << idx) : '0;
        sel    = any ? idx_to_sel(idx) : SEL_N;
    end

endmodule

// File: rtl/rr_output_port_arbiter.sv
// Per-output wormhole arbiter: grants one input until its tail flit transfers,
// then hands off round-robin in the same cycle with no bubble.
module rr_output_port_arbiter #(
    parameter int unsigned NUM_PORTS = 5,
    parameter int unsigned SEL_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0] tail_i,
    input  logic                 out_ready_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [SEL_W-1:0]     sel_o,
    output logic                 valid_o,
    output logic                 busy_o
);
    import noc_arb_pkg::*;

    arb_state_t           state_q;
    logic [NUM_PORTS-1:0] grant_q;
    logic [SEL_W-1:0]     sel_q;
    // Window of ports searched first: every index below the last finisher.
    logic [NUM_PORTS-1:0] ptr_q;

    logic [NUM_PORTS-1:0] next_ptr;
    logic [NUM_PORTS-1:0] pick_req;
    logic [NUM_PORTS-1:0] pick_ptr;
    logic [NUM_PORTS-1:0] pick_winner;
    port_sel_t            pick_sel;
    logic                 pick_any;
    logic                 xfer;
    logic                 tail_xfer;

    always_comb begin
        xfer      = (state_q == LOCKED) && (|(grant_q & req_i)) && out_ready_i;
        tail_xfer = xfer && (|(grant_q & tail_i));
        next_ptr  = grant_q - NUM_PORTS'(1);
        pick_req  = (state_q == LOCKED) ? (req_i & ~grant_q) : req_i;
        pick_ptr  = (state_q == LOCKED) ? next_ptr : ptr_q;
    end

    rr_mask_pick u_pick (
        .req    (pick_req),
        .ptr    (pick_ptr),
        .winner (pick_winner),
        .sel    (pick_sel),
        .any    (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= SEL_N;
            ptr_q   <= '1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_winner;
                        sel_q   <= pick_sel;
                        state_q <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (tail_xfer) begin
                        ptr_q <= next_ptr;
                        if (pick_any) begin
                            grant_q <= pick_winner;
                            sel_q   <= pick_sel;
                        end else begin
                            grant_q <= '0;
                            sel_q   <= SEL_N;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    sel_q   <= SEL_N;
                end
            endcase
        end
    end

    assign grant_o = grant_q;
    assign sel_o   = sel_q;
    assign valid_o = xfer;
    assign busy_o  = (state_q == LOCKED);

endmodule

// File: tb/tb_rr_output_port_arbiter.sv
// Directed scoreboard bench for rr_output_port_arbiter: each stimulus cycle queues
// the hand-computed outputs, and a monitor compares them mid-cycle on the falling edge.
module tb_rr_output_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] req_i = 5'b11111;
    logic [4:0] tail_i = 5'b00000;
    logic       out_ready_i = 1'b1;
    logic [4:0] grant_o;
    logic [2:0] sel_o;
    logic       valid_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      nm;
        logic [4:0] g;
        logic [2:0] s;
        logic       v;
        logic       b;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    rr_output_port_arbiter #(.NUM_PORTS(5), .SEL_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .tail_i      (tail_i),
        .out_ready_i (out_ready_i),
        .grant_o     (grant_o),
        .sel_o       (sel_o),
        .valid_o     (valid_o),
        .busy_o      (busy_o)
    );

    task automatic chk(input string nm, input string field, input logic [4:0] got, input logic [4:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s %s: got %b expected %b", nm, field, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.nm, "grant", grant_o, e.g);
                chk(e.nm, "sel", {2'b00, sel_o}, {2'b00, e.s});
                chk(e.nm, "valid", {4'b0, valid_o}, {4'b0, e.v});
                chk(e.nm, "busy", {4'b0, busy_o}, {4'b0, e.b});
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected before the next rising edge.
    task automatic cyc(input string nm, input logic [4:0] r, input logic [4:0] t, input logic rd,
                       input logic [4:0] eg, input logic [2:0] es, input logic ev, input logic eb);
        exp_t e;
        req_i       = r;
        tail_i      = t;
        out_ready_i = rd;
        e.nm = nm; e.g = eg; e.s = es; e.v = ev; e.b = eb;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        cyc(nm, 5'b11111, 5'b11111, 1'b1, 5'b00000, 3'b000, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin : stimulus
        @(posedge clk);
        #1;
        // 1: reset with all requesting, then a lone N request
        cyc("t1_rst", 5'b11111, 5'b00000, 1'b1, 5'b00000, 3'b000, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc("t1_idle",  5'b10000, 5'b00000, 1'b1, 5'b00000, 3'b000, 1'b0, 1'b0);
        cyc("t1_grant", 5'b10000, 5'b10000, 1'b1, 5'b10000, 3'b000, 1'b1, 1'b1);
        cyc("t1_done",  5'b00000, 5'b00000, 1'b1, 5'b00000, 3'b000, 1'b0, 1'b0);

        // 2: all requesting single-flit packets rotate N,S,W,E,L,N
        do_reset("t2_rst");
        cyc("t2_c0", 5'b11111, 5'b11111, 1'b1, 5'b00000, 3'b000, 1'b0, 1'b0);
        cyc("t2_N",  5'b11111, 5'b11111, 1'b1, 5'b10000, 3'b000, 1'b1, 1'b1);
        cyc("t2_S",  5'b11111, 5'b11111, 1'b1, 5'b01000, 3'b001, 1'b1, 1'b1);
        cyc("t2_W",  5'b11111, 5'b11111, 1'b1, 5'b00100, 3'b010, 1'b1, 1'b1);
        cyc("t2_E",  5'b11111, 5'b11111, 1'b1, 5'b00010, 3'b011, 1'b1, 1'b1);
        cyc("t2_L",  5'b11111, 5'b11111, 1'b1, 5'b00001, 3'b100, 1'b1, 1'b1);
        cyc("t2_N2", 5'b11111, 5'b11111, 1'b1, 5'b10000, 3'b000, 1'b1, 1'b1);
        cyc("t2_S2_bubble", 5'b00000, 5'b00000, 1'b1, 5'b01000, 3'b001, 1'b0, 1'b1);

        // 3: W 3-flit packet, N arrives after flit 1 and must wait; N's tail is ignored meanwhile
        do_reset("t3_rst");
        cyc("t3_idle", 5'b00100, 5'b00000, 1'b1, 5'b00000, 3'b000, 1'b0, 1'b0);
        cyc("t3_f1",   5'b00100, 5'b00000, 1'b1, 5'b00100, 3'b010, 1'b1, 1'b1);
        cyc("t3_f2",   5'b10100, 5'b10000, 1'b1, 5'b00100, 3'b010, 1'b1, 1'b1);
        cyc("t3_f3",   5'b10100, 5'b00100, 1'b1, 5'b00100, 3'b010, 1'b1, 1'b1);
        cyc("t3_N",    5'b10000, 5'b10000, 1'b1, 5'b10000, 3'b000, 1'b1, 1'b1);
        cyc("t3_idle2", 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'b000, 1'b0, 1'b0);

        // 4: E stalled by out_ready_i=0 for 4 cycles with its tail pending
        cyc("t4_idle", 5'b00010, 5'b00000, 1'b1, 5'b00000, 3'b000, 1'b0, 1'b0);
        cyc("t4_f1",   5'b00010, 5'b00000, 1'b1, 5'b00010, 3'b011, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc("t4_stall", 5'b00011, 5'b00010, 1'b0, 5'b00010, 3'b011, 1'b0, 1'b1);
        end
        cyc("t4_tail",  5'b00011, 5'b00010, 1'b1, 5'b00010, 3'b011, 1'b1, 1'b1);
        cyc("t4_L",     5'b00001, 5'b00001, 1'b1, 5'b00001, 3'b100, 1'b1, 1'b1);
        cyc("t4_idle2", 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'b000, 1'b0, 1'b0);
        // pointer past L wraps: N beats W
        cyc("t4_wrap_req", 5'b10100, 5'b00000, 1'b1, 5'b00000, 3'b000, 1'b0, 1'b0);
        cyc("t4_wrap_N",   5'b10100, 5'b00000, 1'b1, 5'b10000, 3'b000, 1'b1, 1'b1);

        // 5: granted E bubbles for 2 cycles while L waits; stray tails ignored
        do_reset("t5_rst");
        cyc("t5_idle",  5'b00010, 5'b00000, 1'b1, 5'b00000, 3'b000, 1'b0, 1'b0);
        cyc("t5_f1",    5'b00011, 5'b00000, 1'b1, 5'b00010, 3'b011, 1'b1, 1'b1);
        cyc("t5_bub1",  5'b00001, 5'b00001, 1'b1, 5'b00010, 3'b011, 1'b0, 1'b1);
        cyc("t5_bub2",  5'b00001, 5'b00010, 1'b1, 5'b00010, 3'b011, 1'b0, 1'b1);
        cyc("t5_tail",  5'b00011, 5'b00010, 1'b1, 5'b00010, 3'b011, 1'b1, 1'b1);
        cyc("t5_L",     5'b00001, 5'b00001, 1'b1, 5'b00001, 3'b100, 1'b1, 1'b1);
        cyc("t5_idle2", 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'b000, 1'b0, 1'b0);

        // 6: async reset mid-packet, then N wins and re-requests after going idle
        cyc("t6_idle", 5'b01000, 5'b00000, 1'b1, 5'b00000, 3'b000, 1'b0, 1'b0);
        cyc("t6_S",    5'b01000, 5'b00000, 1'b1, 5'b01000, 3'b001, 1'b1, 1'b1);
        rst_n = 1'b0;
        cyc("t6_async_rst", 5'b11111, 5'b00000, 1'b1, 5'b00000, 3'b000, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc("t6_rel",   5'b11111, 5'b00000, 1'b1, 5'b00000, 3'b000, 1'b0, 1'b0);
        cyc("t6_N",     5'b10000, 5'b10000, 1'b1, 5'b10000, 3'b000, 1'b1, 1'b1);
        cyc("t6_gap",   5'b10000, 5'b10000, 1'b1, 5'b00000, 3'b000, 1'b0, 1'b0);
        cyc("t6_reN",   5'b10000, 5'b10000, 1'b1, 5'b10000, 3'b000, 1'b1, 1'b1);
        cyc("t6_end",   5'b00000, 5'b00000, 1'b1, 5'b00000, 3'b000, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
